// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, redirect flush and memory freeze control with registered EX forwarding selects; HAZ_PERF_CNT_EN adds stall/flush counters.
// Latency: stall/flush/bubble are combinational from ID and the record state; forwarding selects follow one edge after ID acceptance.
// Backpressure: mem_busy_i freezes every record and select; a load-use hazard holds PC/IF-ID and inserts a bubble into EX.
module pipe_hazard_ctrl #(
   parameter int  STAGES     = 5,
   parameter int  REG_ADDR_W = 5,
   parameter int  LOAD_LAT   = 1,
   localparam int NS         = STAGES - 2,
   localparam int FWD_W      = $clog2(NS)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_reg_write_i,
   input  logic                  id_mem_read_i,
   input  logic                  ex_redirect_i,
   input  logic                  mem_busy_i,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic                  bubble_o,
   output logic [FWD_W-1:0]      fwd_rs1_o,
   output logic [FWD_W-1:0]      fwd_rs2_o,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           flush_cnt_o
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  is_load;
   } rec_t;

   rec_t             rec_q [NS];
   rec_t             rec_d [NS];
   logic [FWD_W-1:0] fwd1_q, fwd1_d;
   logic [FWD_W-1:0] fwd2_q, fwd2_d;

   logic [FWD_W-1:0] sel1, sel2;
   logic             lu1, lu2;
   logic             hazard;
   logic             freeze, redirect, lu_stall, accept;

   // Scan oldest to youngest so the youngest producer wins; the WB record is
   // never a source because the regfile writes before it is read.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      lu1  = 1'b0;
      lu2  = 1'b0;
      for (int j = NS - 2; j >= 0; j--) begin
         if (rec_q[j].valid && rec_q[j].reg_write && id_use_rs1_i &&
             (id_rs1_i != '0) && (rec_q[j].rd == id_rs1_i)) begin
            sel1 = FWD_W'(j + 1);
            lu1  = rec_q[j].is_load && (j < LOAD_LAT);
         end
         if (rec_q[j].valid && rec_q[j].reg_write && id_use_rs2_i &&
             (id_rs2_i != '0) && (rec_q[j].rd == id_rs2_i)) begin
            sel2 = FWD_W'(j + 1);
            lu2  = rec_q[j].is_load && (j < LOAD_LAT);
         end
      end
   end

   assign hazard   = id_valid_i && (lu1 || lu2);
   assign freeze   = mem_busy_i;
   assign redirect = !freeze && ex_redirect_i;
   assign lu_stall = !freeze && !ex_redirect_i && hazard;
   assign accept   = !freeze && !ex_redirect_i && !hazard;

   assign stall_o  = freeze || lu_stall;
   assign flush_o  = redirect;
   assign bubble_o = redirect || lu_stall;

   always_comb begin
      rec_d  = rec_q;
      fwd1_d = fwd1_q;
      fwd2_d = fwd2_q;
      if (!freeze) begin
         for (int i = 1; i < NS; i++) begin
            rec_d[i] = rec_q[i-1];
         end
         rec_d[0] = '0;
         fwd1_d   = '0;
         fwd2_d   = '0;
         if (accept) begin
            rec_d[0].valid     = id_valid_i;
            rec_d[0].rd        = id_rd_i;
            rec_d[0].reg_write = id_reg_write_i;
            rec_d[0].is_load   = id_mem_read_i;
            if (id_valid_i) begin
               fwd1_d = sel1;
               fwd2_d = sel2;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < NS; i++) begin
            rec_q[i] <= '0;
         end
         fwd1_q <= '0;
         fwd2_q <= '0;
      end else begin
         rec_q  <= rec_d;
         fwd1_q <= fwd1_d;
         fwd2_q <= fwd2_d;
      end
   end

   assign fwd_rs1_o = fwd1_q;
   assign fwd_rs2_o = fwd2_q;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters: frozen cycles are not counted as load-use stalls.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (lu_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule
